ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each access is a registered IDLE -> ISSUE (-> RWAIT) -> IDLE sequence.
module ram_arbiter #(
    parameter int unsigned DEP   = 32,
    parameter int unsigned WID_D = 4,
    parameter int unsigned WID_A = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             wr_a,
    input  logic             wr_b,
    input  logic [WID_A-1:0] addr_a,
    input  logic [WID_A-1:0] addr_b,
    input  logic [WID_D-1:0] din_a,
    input  logic [WID_D-1:0] din_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic [WID_D-1:0] dout_a,
    output logic [WID_D-1:0] dout_b,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [WID_A-1:0] mem_addr,
    output logic [WID_D-1:0] mem_wdata,
    input  logic [WID_D-1:0] mem_rdata,
    output logic             busy,
    output logic [7:0]       conflict_cnt
);

    if (DEP > (32'd1 << WID_A)) begin : g_dep_check
        $error("ram_arbiter: DEP exceeds the address range of WID_A");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RWAIT
    } state_t;

    state_t           state_q;
    logic             last_b_q;
    logic             port_b_q;
    logic [7:0]       cnt_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             rvalid_a_q;
    logic             rvalid_b_q;
    logic [WID_D-1:0] dout_a_q;
    logic [WID_D-1:0] dout_b_q;
    logic             mem_cs_q;
    logic             mem_we_q;
    logic [WID_A-1:0] mem_addr_q;
    logic [WID_D-1:0] mem_wdata_q;
    logic             busy_q;

    logic             both_req;
    logic             win_b;
    logic             sel_wr;
    logic [WID_A-1:0] sel_addr;
    logic [WID_D-1:0] sel_din;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        both_req = req_a & req_b;
        win_b    = both_req ? ~last_b_q : req_b;
        sel_wr   = win_b ? wr_b   : wr_a;
        sel_addr = win_b ? addr_b : addr_a;
        sel_din  = win_b ? din_b  : din_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_b_q    <= 1'b1;
            port_b_q    <= 1'b0;
            cnt_q       <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_a | req_b) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        gnt_a_q     <= ~win_b;
                        gnt_b_q     <= win_b;
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= sel_wr;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_din;
                        port_b_q    <= win_b;
                        last_b_q    <= win_b;
                        if (both_req && (cnt_q != 8'hFF)) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    // mem_we_q still holds the latched direction of this access
                    if (mem_we_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (port_b_q) begin
                        dout_b_q   <= mem_rdata;
                        rvalid_b_q <= 1'b1;
                    end else begin
                        dout_a_q   <= mem_rdata;
                        rvalid_a_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign rvalid_a     = rvalid_a_q;
    assign rvalid_b     = rvalid_b_q;
    assign dout_a       = dout_a_q;
    assign dout_b       = dout_b_q;
    assign mem_cs       = mem_cs_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a transaction-level
// model: per sample it predicts grant, RAM cycle, read return and counters.
module tb_ram_arbiter;

    localparam int unsigned DEP   = 32;
    localparam int unsigned WID_D = 4;
    localparam int unsigned WID_A = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
    logic [WID_A-1:0] addr_a = '0, addr_b = '0;
    logic [WID_D-1:0] din_a = '0, din_b = '0;
    logic             gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [WID_D-1:0] dout_a, dout_b;
    logic             mem_cs, mem_we;
    logic [WID_A-1:0] mem_addr;
    logic [WID_D-1:0] mem_wdata;
    logic [WID_D-1:0] mem_rdata = '0;
    logic             busy;
    logic [7:0]       conflict_cnt;

    ram_arbiter #(.DEP(DEP), .WID_D(WID_D), .WID_A(WID_A)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .dout_a(dout_a), .dout_b(dout_b),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    logic [WID_D-1:0] ram [DEP] = '{default: '0};
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic             gnt_a, gnt_b, rv_a, rv_b, cs, we, busy, dup, dport;
        logic [WID_A-1:0] addr;
        logic [WID_D-1:0] wdata, dval;
    } slot_t;

    slot_t            slots [4];
    logic [WID_D-1:0] mem_m [DEP] = '{default: '0};
    logic [WID_D-1:0] dout_m [2];
    int unsigned      cyc = 0, next_sample = 0, cnt_m = 0;
    int               last_m = 1;

    logic             hold [2];
    logic             h_wr [2];
    logic [WID_A-1:0] h_addr [2];
    logic [WID_D-1:0] h_din [2];
    int unsigned      keep [2];
    bit               rnd_mode = 1'b0;

    int unsigned      n_checks = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) slots[i] = '0;
        dout_m[0]   = '0;
        dout_m[1]   = '0;
        cnt_m       = 0;
        last_m      = 1;
        next_sample = cyc + 1;
    endtask

    task automatic drive();
        req_a  = hold[0];
        wr_a   = hold[0] ? h_wr[0]   : 1'($urandom);
        addr_a = hold[0] ? h_addr[0] : WID_A'($urandom);
        din_a  = hold[0] ? h_din[0]  : WID_D'($urandom);
        req_b  = hold[1];
        wr_b   = hold[1] ? h_wr[1]   : 1'($urandom);
        addr_b = hold[1] ? h_addr[1] : WID_A'($urandom);
        din_b  = hold[1] ? h_din[1]  : WID_D'($urandom);
    endtask

    task automatic post(input int p, input logic w, input logic [WID_A-1:0] a,
                        input logic [WID_D-1:0] d, input int unsigned k);
        hold[p] = 1'b1; h_wr[p] = w; h_addr[p] = a; h_din[p] = d; keep[p] = k;
        drive();
    endtask

    task automatic new_random(input int p);
        hold[p]   = 1'b1;
        h_wr[p]   = 1'($urandom);
        h_addr[p] = ($urandom_range(0, 1) == 0) ? WID_A'($urandom_range(0, 3)) : WID_A'($urandom);
        h_din[p]  = WID_D'($urandom);
        keep[p]   = 0;
    endtask

    task automatic step();
        slot_t            s;
        logic [1:0]       idx;
        logic             both, win_b, w_wr, g;
        logic [WID_A-1:0] w_addr;
        logic [WID_D-1:0] w_din;
        @(posedge clk);
        cyc++;
        idx = 2'(cyc);
        if (rst) begin
            model_reset();
        end else if (cyc >= next_sample && (req_a || req_b)) begin
            both   = req_a && req_b;
            win_b  = both ? (last_m == 0) : req_b;
            w_wr   = win_b ? wr_b : wr_a;
            w_addr = win_b ? addr_b : addr_a;
            w_din  = win_b ? din_b : din_a;
            last_m = win_b ? 1 : 0;
            if (both && cnt_m < 255) cnt_m++;
            slots[idx].gnt_a = !win_b;
            slots[idx].gnt_b = win_b;
            slots[idx].cs    = 1'b1;
            slots[idx].we    = w_wr;
            slots[idx].addr  = w_addr;
            slots[idx].wdata = w_din;
            slots[idx].busy  = 1'b1;
            if (w_wr) begin
                mem_m[w_addr] = w_din;
                next_sample   = cyc + 2;
            end else begin
                slots[2'(cyc + 1)].busy  = 1'b1;
                slots[2'(cyc + 2)].rv_a  = !win_b;
                slots[2'(cyc + 2)].rv_b  = win_b;
                slots[2'(cyc + 2)].dup   = 1'b1;
                slots[2'(cyc + 2)].dport = win_b;
                slots[2'(cyc + 2)].dval  = mem_m[w_addr];
                next_sample = cyc + 3;
            end
        end
        @(negedge clk);
        s = slots[idx];
        slots[idx] = '0;
        if (s.dup) dout_m[s.dport] = s.dval;
        chk("gnt_a",     32'(gnt_a),        32'(s.gnt_a));
        chk("gnt_b",     32'(gnt_b),        32'(s.gnt_b));
        chk("rvalid_a",  32'(rvalid_a),     32'(s.rv_a));
        chk("rvalid_b",  32'(rvalid_b),     32'(s.rv_b));
        chk("mem_cs",    32'(mem_cs),       32'(s.cs));
        chk("mem_we",    32'(mem_we),       32'(s.we));
        chk("mem_addr",  32'(mem_addr),     32'(s.addr));
        chk("mem_wdata", 32'(mem_wdata),    32'(s.wdata));
        chk("busy",      32'(busy),         32'(s.busy));
        chk("dout_a",    32'(dout_a),       32'(dout_m[0]));
        chk("dout_b",    32'(dout_b),       32'(dout_m[1]));
        chk("conflict",  32'(conflict_cnt), cnt_m);
        for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? s.gnt_a : s.gnt_b;
            if (g) begin
                if (keep[p] > 0)                           keep[p]--;
                else if (rnd_mode && $urandom_range(0, 1)) new_random(p);
                else                                       hold[p] = 1'b0;
            end else if (!hold[p] && rnd_mode && $urandom_range(0, 2) == 0) begin
                new_random(p);
            end
        end
        drive();
    endtask

    task automatic drain(input int unsigned max_steps);
        int unsigned i = 0;
        while ((hold[0] || hold[1] || cyc + 1 < next_sample) && i < max_steps) begin
            step();
            i++;
        end
        if (i >= max_steps) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_gnt",      32'({gnt_a, gnt_b}), 32'd0);
        chk("rst_rvalid",   32'({rvalid_a, rvalid_b}), 32'd0);
        chk("rst_mem",      32'({mem_cs, mem_we, mem_addr, mem_wdata}), 32'd0);
        chk("rst_dout",     32'({dout_a, dout_b}), 32'd0);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        hold[0] = 1'b0; hold[1] = 1'b0; keep[0] = 0; keep[1] = 0;
        h_wr[0] = 1'b0; h_wr[1] = 1'b0; h_addr[0] = '0; h_addr[1] = '0;
        h_din[0] = '0; h_din[1] = '0;
        dout_m[0] = '0; dout_m[1] = '0;
        #1;
        do_reset();

        // write 31 <- 0 then read 31
        post(0, 1'b1, 5'd31, 4'd0, 0);
        drain(20);
        post(0, 1'b0, 5'd31, 4'd0, 0);
        drain(20);

        // repeated reads of 12 from both ports alternate
        post(0, 1'b1, 5'd12, 4'd9, 0);
        drain(20);
        post(0, 1'b0, 5'd12, 4'd0, 3);
        post(1, 1'b0, 5'd12, 4'd0, 3);
        drain(60);

        // same-address writes with last winner A: B first, then A persists
        post(0, 1'b0, 5'd5, 4'd0, 0);
        drain(20);
        post(0, 1'b1, 5'd12, 4'd12, 0);
        post(1, 1'b1, 5'd12, 4'd7, 0);
        drain(20);
        post(0, 1'b0, 5'd12, 4'd0, 0);
        drain(20);
        chk("same_addr_rd", 32'(dout_a), 32'd12);

        // reset while an A read sits in RWAIT
        post(0, 1'b1, 5'd9, 4'd5, 0);
        drain(20);
        post(0, 1'b0, 5'd9, 4'd0, 0);
        drain(20);
        post(0, 1'b0, 5'd9, 4'd0, 0);
        step();
        step();
        do_reset();
        post(0, 1'b0, 5'd9, 4'd0, 0);
        drain(20);
        chk("post_rst_rd", 32'(dout_a), 32'd5);

        // simultaneous writes right after reset
        do_reset();
        post(0, 1'b1, 5'd0, 4'd12, 0);
        post(1, 1'b1, 5'd31, 4'd10, 0);
        drain(20);
        chk("conflict_once", 32'(conflict_cnt), 32'd1);

        // long run of ties saturates the conflict counter
        do_reset();
        post(0, 1'b1, 5'd1, 4'd3, 200);
        post(1, 1'b1, 5'd2, 4'd4, 200);
        drain(1200);
        chk("conflict_sat", 32'(conflict_cnt), 32'd255);

        rnd_mode = 1'b1;
        repeat (2000) step();
        rnd_mode = 1'b0;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
